ps_swallow_ctrl: RTL and testbench
==================================

Name: ps_swallow_ctrl

Overview:
- Synchronous programmable P/S counter pair. It is the successor to the ripple P-counter and controls a dual-modulus (N/N+1) prescaler in the fractional-N divider.
- It is clocked by the prescaler output. The total divide ratio is N*P_eff + S_eff.
- It generates the modulus-control (MC) signal, the frame-boundary load strobe (LDo) and the divided output (Fout).
- Pi/Si are re-sampled glitch-free at every frame boundary, so the sigma-delta modulator can update them each frame.

Parameters:
WIDTH, 5, bit width of Pi and of the P down-counter
S_WIDTH, 4, bit width of Si and of the S down-counter; legal only when S_WIDTH <= WIDTH (elaboration error otherwise)

Ports:
Fin  input  1  clock: prescaler output, rising-edge active
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; when low, all state holds
Pi  input  WIDTH  P value (frame length in Fin cycles)
Si  input  S_WIDTH  S value (MC-high cycles per frame)
MC  output  1  modulus control: 1 selects N+1, 0 selects N; registered
LDo  output  1  high during the last Fin cycle of each frame; registered
Fout  output  1  divided output; registered
err  output  1  sticky flag: an out-of-range Pi/Si was clamped at some load

Behaviour:
- Reset (async, rst_n=0): state=IDLE; p_cnt, s_cnt = 0; MC, LDo, Fout, err = 0. Reset mid-frame aborts the frame immediately.
- States:
  - IDLE: all outputs 0. On the first rising Fin edge with en=1, perform a LOAD and go to RUN.
  - RUN: remains in RUN until reset.
- LOAD (at a frame-boundary edge):
  - P_eff = max(Pi, 2).
  - S_eff = min(Si zero-extended to WIDTH, P_eff).
  - err <= err | (Pi < 2) | (Si > P_eff).
  - p_cnt <= P_eff - 1.
  - s_cnt loaded so that MC is high for exactly S_eff cycles.
  - Pi/Si are sampled only at this edge; changes at any other time have no effect on the current frame.
- Frame cycle index c = P_eff - 1 - p_cnt, with c = 0 .. P_eff-1. Each enabled edge in RUN decrements p_cnt. The edge that ends cycle c = P_eff-1 (p_cnt==0) is a LOAD. Frames are back-to-back with no gap cycle.
- MC = 1 for c in [0, S_eff-1], else 0. S_eff=0 gives MC=0 all frame; S_eff=P_eff gives MC=1 all frame.
- LDo = 1 only at c = P_eff-1, i.e. exactly one Fin cycle per frame.
- Fout (default) = 1 only at c = 0: a one-cycle pulse per frame, period P_eff Fin cycles.
- All outputs change only on rising Fin edges, except for the async reset. Latency from IDLE: the first LOAD edge makes c=0 visible immediately after it (MC/Fout valid in the same cycle).
- en=0: p_cnt, s_cnt, the state and all outputs hold their values. The frame is lengthened by the number of disabled cycles. en=0 in IDLE keeps IDLE.
- Arithmetic is unsigned and there is no wrap. The maximum P_eff is 2^WIDTH - 1; Pi = all-ones is legal.
- err is cleared only by rst_n.

Optional Feature:
DUTY50_EN
- Defined: Fout = 1 for c in [0, ceil(P_eff/2) - 1], else 0, giving near-50% duty. For example, P_eff=5 gives 3 cycles high, 2 low; P_eff=2 gives 1 high, 1 low. The threshold is computed at LOAD from P_eff.
- Undefined: Fout is the one-cycle pulse at c=0.
- MC, LDo and err are identical in both builds.

Test Plan:
1. Pi=5, Si=2, en=1 steady for 20 cycles:
   - LDo high every 5th cycle.
   - MC pattern 1,1,0,0,0 repeating.
   - Fout pulse each frame at c=0.
   - err=0.
2. Pi changed 5->8 at c=2 of a frame: current frame still 5 cycles; the next frame is 8 cycles with the LDo spacing now 8.
3. Pi=4, Si=7: S_eff=4, MC constantly 1, frame 4 cycles, err=1 and stays 1 after Si is returned to 1.
4. Pi=0, then Pi=1 (Si=0): both give a frame of 2 cycles with LDo on alternate cycles, MC=0 and err=1.
5. Pi=6, Si=3, en=0 for 3 cycles at c=1: outputs held; the frame spans 9 Fin edges; MC high for 3 enabled cycles.
6. rst_n pulsed low at c=3 with Pi=5:
   - All outputs and err go to 0 immediately.
   - The first edge after release starts a new frame at c=0.
   - Repeat in the DUTY50_EN build with Pi=5: Fout pattern 1,1,1,0,0.

Source files
------------

// File: rtl/ps_swallow_ctrl.sv
// ps_swallow_ctrl: synchronous programmable P/S counter pair that drives the
// modulus control of a dual-modulus (N/N+1) prescaler. It runs on the prescaler
// output Fin and gives a total divide ratio of N*P_eff + S_eff.
//
// Optional feature macro: DUTY50_EN
//   undefined (default): Fout is a one-cycle pulse at the first cycle of each frame
//   defined            : Fout stays high for the first ceil(P_eff/2) cycles of each frame
module ps_swallow_ctrl #(
  parameter int WIDTH   = 5,
  parameter int S_WIDTH = 4
) (
  input  logic               Fin,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   Pi,
  input  logic [S_WIDTH-1:0] Si,
  output logic               MC,
  output logic               LDo,
  output logic               Fout,
  output logic               err
);

  // The S counter is loaded from Si, which may never exceed the P range.
  if (S_WIDTH > WIDTH) begin : gWidthCheck
    $error("ps_swallow_ctrl: S_WIDTH must not exceed WIDTH");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pCnt_q, pCnt_d;
  logic [S_WIDTH-1:0] sCnt_q, sCnt_d;
  logic               mc_q, mc_d;
  logic               ldo_q, ldo_d;
  logic               fout_q, fout_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   pEff;
  logic [WIDTH-1:0]   siExt;
  logic [WIDTH-1:0]   sEff;
  logic               clampHit;
  logic               doLoad;

`ifdef DUTY50_EN
  // Fout stays high while the P counter is at or above floor(P_eff/2),
  // which is the same as cycle index c < ceil(P_eff/2).
  logic [WIDTH-1:0]   half_q, half_d;
`endif

  // Clamp the incoming frame values into range and flag any clamping.
  always_comb begin
    pEff     = (Pi < WIDTH'(2)) ? WIDTH'(2) : Pi;
    siExt    = WIDTH'(Si);
    sEff     = (siExt > pEff) ? pEff : siExt;
    clampHit = (Pi < WIDTH'(2)) | (siExt > pEff);
  end

  // Next-state logic: a load happens on the first enabled edge out of IDLE
  // and on the enabled edge that ends the last cycle of every frame.
  // sCnt holds the number of MC-high cycles still to go, including the
  // current one, so MC is simply "sCnt is non-zero" after each update.
  always_comb begin
    state_d = state_q;
    pCnt_d  = pCnt_q;
    sCnt_d  = sCnt_q;
    mc_d    = mc_q;
    ldo_d   = ldo_q;
    fout_d  = fout_q;
    err_d   = err_q;
`ifdef DUTY50_EN
    half_d  = half_q;
`endif
    doLoad  = en && ((state_q == IDLE) || (pCnt_q == '0));

    if (en) begin
      if (doLoad) begin
        state_d = RUN;
        pCnt_d  = pEff - WIDTH'(1);
        sCnt_d  = S_WIDTH'(sEff);
        mc_d    = (sEff != '0);
        ldo_d   = (pCnt_d == '0);
        fout_d  = 1'b1;
        err_d   = err_q | clampHit;
`ifdef DUTY50_EN
        half_d  = pEff >> 1;
`endif
      end else begin
        pCnt_d  = pCnt_q - WIDTH'(1);
        sCnt_d  = (sCnt_q == '0) ? '0 : (sCnt_q - S_WIDTH'(1));
        mc_d    = (sCnt_d != '0);
        ldo_d   = (pCnt_d == '0);
`ifdef DUTY50_EN
        fout_d  = (pCnt_d >= half_q);
`else
        fout_d  = 1'b0;
`endif
      end
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge Fin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pCnt_q  <= '0;
      sCnt_q  <= '0;
      mc_q    <= 1'b0;
      ldo_q   <= 1'b0;
      fout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pCnt_q  <= pCnt_d;
      sCnt_q  <= sCnt_d;
      mc_q    <= mc_d;
      ldo_q   <= ldo_d;
      fout_q  <= fout_d;
      err_q   <= err_d;
    end
  end

`ifdef DUTY50_EN
  // Duty threshold captured at every load.
  always_ff @(posedge Fin or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= '0;
    end else begin
      half_q <= half_d;
    end
  end
`endif

  assign MC   = mc_q;
  assign LDo  = ldo_q;
  assign Fout = fout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ps_swallow_ctrl.sv
// Testbench for ps_swallow_ctrl: directed scenarios plus randomized traffic,
// all checked against a frame-level reference model (cycle index within the
// current frame, with outputs derived from that index).
module tb_ps_swallow_ctrl;

  localparam int WIDTH   = 5;
  localparam int S_WIDTH = 4;

  logic               Fin   = 1'b0;
  logic               rst_n = 1'b0;
  logic               en    = 1'b0;
  logic [WIDTH-1:0]   Pi    = '0;
  logic [S_WIDTH-1:0] Si    = '0;
  logic               MC;
  logic               LDo;
  logic               Fout;
  logic               err;

  int checks = 0;
  int passes = 0;

  // Reference model state: running flag, frame length, MC-high count,
  // cycle index inside the frame, sticky error.
  bit mRun;
  int mP;
  int mS;
  int mC;
  bit mErr;

  ps_swallow_ctrl #(
    .WIDTH  (WIDTH),
    .S_WIDTH(S_WIDTH)
  ) dut (
    .Fin  (Fin),
    .rst_n(rst_n),
    .en   (en),
    .Pi   (Pi),
    .Si   (Si),
    .MC   (MC),
    .LDo  (LDo),
    .Fout (Fout),
    .err  (err)
  );

  // Prescaler output stand-in.
  always #5 Fin = ~Fin;

  task automatic modelReset();
    mRun = 1'b0;
    mP   = 0;
    mS   = 0;
    mC   = 0;
    mErr = 1'b0;
  endtask

  // One rising edge of Fin seen by the model.
  task automatic modelEdge();
    int p;
    int s;
    if (en) begin
      if (!mRun || mC == mP - 1) begin
        p = (int'(Pi) < 2) ? 2 : int'(Pi);
        s = int'(Si);
        if (int'(Pi) < 2 || s > p) mErr = 1'b1;
        mP   = p;
        mS   = (s > p) ? p : s;
        mC   = 0;
        mRun = 1'b1;
      end else begin
        mC = mC + 1;
      end
    end
  endtask

  // Expected {MC, LDo, Fout, err} from the model's frame position.
  function automatic logic [3:0] expOut();
    logic f;
    if (!mRun) return {3'b000, mErr};
`ifdef DUTY50_EN
    f = (mC < (mP + 1) / 2);
`else
    f = (mC == 0);
`endif
    return {(mC < mS), (mC == mP - 1), f, mErr};
  endfunction

  // Advance one Fin edge and settle just after it.
  task automatic tick();
    @(posedge Fin);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    @(negedge Fin);
    rst_n = 1'b0;
    #1;
    modelReset();
    @(negedge Fin);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1;
    Pi = 5'd5;
    Si = 4'd2;
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge Fin);
    checks++;
    if ({MC, LDo, Fout, err} !== 4'b0000)
      $display("[TB] FAIL reset_outputs got=%b want=%b", {MC, LDo, Fout, err}, 4'b0000);
    else passes++;
    en = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({MC, LDo, Fout, err} !== 4'b0000)
        $display("[TB] FAIL idle_hold k=%0d got=%b want=%b", k, {MC, LDo, Fout, err}, 4'b0000);
      else passes++;
    end
  endtask

  task automatic test_steady();
    int ldoCount;
    en = 1'b1;
    Pi = 5'd5;
    Si = 4'd2;
    doReset();
    ldoCount = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (LDo) ldoCount++;
      checks++;
      if ({MC, LDo, Fout, err} !== expOut())
        $display("[TB] FAIL steady k=%0d got=%b want=%b", k, {MC, LDo, Fout, err}, expOut());
      else passes++;
      checks++;
      if (MC !== logic'((k % 5) < 2))
        $display("[TB] FAIL steady_mc k=%0d got=%b want=%b", k, MC, logic'((k % 5) < 2));
      else passes++;
    end
    checks++;
    if (ldoCount != 4)
      $display("[TB] FAIL steady_ldo_count got=%0d want=4", ldoCount);
    else passes++;
  endtask

  task automatic test_pi_change();
    int ldoAt[$];
    en = 1'b1;
    Pi = 5'd5;
    Si = 4'd2;
    doReset();
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k == 7) Pi = 5'd8;
      if (LDo) ldoAt.push_back(k);
      checks++;
      if ({MC, LDo, Fout, err} !== expOut())
        $display("[TB] FAIL pi_change k=%0d got=%b want=%b", k, {MC, LDo, Fout, err}, expOut());
      else passes++;
    end
    checks++;
    if (ldoAt.size() < 4 || ldoAt[1] != 9 || ldoAt[2] != 17 || ldoAt[3] != 25)
      $display("[TB] FAIL pi_change_spacing got=%p want=4,9,17,25", ldoAt);
    else passes++;
  endtask

  task automatic test_clamp_s();
    en = 1'b1;
    Pi = 5'd4;
    Si = 4'd7;
    doReset();
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 7) Si = 4'd1;
      checks++;
      if ({MC, LDo, Fout, err} !== expOut())
        $display("[TB] FAIL clamp_s k=%0d got=%b want=%b", k, {MC, LDo, Fout, err}, expOut());
      else passes++;
      checks++;
      if (err !== 1'b1 || (k < 8 && MC !== 1'b1))
        $display("[TB] FAIL clamp_s_flags k=%0d got=%b%b want=11", k, MC, err);
      else passes++;
    end
  endtask

  task automatic test_clamp_p();
    en = 1'b1;
    Pi = 5'd0;
    Si = 4'd0;
    doReset();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 5) Pi = 5'd1;
      checks++;
      if ({MC, LDo, err} !== {1'b0, logic'(k % 2), 1'b1})
        $display("[TB] FAIL clamp_p k=%0d got=%b want=%b", k, {MC, LDo, err}, {1'b0, logic'(k % 2), 1'b1});
      else passes++;
      checks++;
      if ({MC, LDo, Fout, err} !== expOut())
        $display("[TB] FAIL clamp_p_model k=%0d got=%b want=%b", k, {MC, LDo, Fout, err}, expOut());
      else passes++;
    end
  endtask

  task automatic test_enable();
    logic [3:0] held;
    int edges;
    bit seen;
    en = 1'b1;
    Pi = 5'd6;
    Si = 4'd3;
    doReset();
    tick();
    tick();
    edges = 2;
    held = {MC, LDo, Fout, err};
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      edges++;
      checks++;
      if ({MC, LDo, Fout, err} !== held)
        $display("[TB] FAIL enable_hold k=%0d got=%b want=%b", k, {MC, LDo, Fout, err}, held);
      else passes++;
    end
    en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      edges++;
      seen = LDo;
      checks++;
      if ({MC, LDo, Fout, err} !== expOut())
        $display("[TB] FAIL enable_run k=%0d got=%b want=%b", k, {MC, LDo, Fout, err}, expOut());
      else passes++;
    end
    checks++;
    if (!seen || edges != 9)
      $display("[TB] FAIL enable_frame_len got=%0d want=9", edges);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    en = 1'b1;
    Pi = 5'd5;
    Si = 4'd7;
    doReset();
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (err !== 1'b1 || mC != 3)
      $display("[TB] FAIL midframe_pre got=%b want=1", err);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checks++;
    if ({MC, LDo, Fout, err} !== 4'b0000)
      $display("[TB] FAIL midframe_reset got=%b want=%b", {MC, LDo, Fout, err}, 4'b0000);
    else passes++;
    #1;
    rst_n = 1'b1;
    Si = 4'd2;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({MC, LDo, Fout, err} !== expOut())
        $display("[TB] FAIL midframe_restart k=%0d got=%b want=%b", k, {MC, LDo, Fout, err}, expOut());
      else passes++;
    end
    checks++;
    if (mC != 4 || LDo !== 1'b1)
      $display("[TB] FAIL midframe_c0 got=%b want=1", LDo);
    else passes++;
  endtask

  task automatic test_random();
    en = 1'b1;
    doReset();
    for (int k = 0; k < 600; k++) begin
      Pi = WIDTH'($urandom_range(0, 31));
      Si = S_WIDTH'($urandom_range(0, 15));
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 79) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checks++;
        if ({MC, LDo, Fout, err} !== 4'b0000)
          $display("[TB] FAIL random_reset k=%0d got=%b want=%b", k, {MC, LDo, Fout, err}, 4'b0000);
        else passes++;
        #1;
        rst_n = 1'b1;
      end
      tick();
      checks++;
      if ({MC, LDo, Fout, err} !== expOut())
        $display("[TB] FAIL random k=%0d Pi=%0d Si=%0d got=%b want=%b", k, Pi, Si, {MC, LDo, Fout, err}, expOut());
      else passes++;
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_steady();
    test_pi_change();
    test_clamp_s();
    test_clamp_p();
    test_enable();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
